// File: rtl/uart_tx.sv
// uart_tx: byte-wide transmit FIFO feeding an 8N1 serial transmitter.
// The bit period is round(CLK_FREQ/BAUD_RATE) clock cycles. The line output
// is registered and lags the FSM state by one cycle. This also gives the
// two-edge latency from an accepted byte to the start bit.
// Optional feature: define UART_TX_PARITY_EN to insert an even parity bit
// between the data bits and the stop bit (8E1, 11-bit frame). The default
// build (macro undefined) sends 8N1 frames of 10 bits.
module uart_tx #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk_100m00,
  input  logic       uart_rst,
  input  logic [7:0] uart_wr_data,
  input  logic       uart_wr_valid,
  output logic       uart_wr_ready,
  output logic       uart_txd,
  output logic       tx_busy
);

  // Bit period in clock cycles, rounded to the nearest integer.
  localparam int DIV    = (CLK_FREQ + BAUD_RATE / 2) / BAUD_RATE;
  localparam int CNT_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FCNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(DIV - 1);
  localparam logic [FCNT_W-1:0] FIFO_FULL = FCNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  // FIFO storage and bookkeeping
  logic [7:0]        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [FCNT_W-1:0] count_reg, count_next;
  logic              ready_reg;
  logic              push, pop;
  logic              fifo_nonempty;

  // Transmitter state
  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  baud_cnt_reg, baud_cnt_next;
  logic [2:0]        bit_cnt_reg, bit_cnt_next;
  logic [7:0]        shift_reg, shift_next;
  logic              txd_reg, txd_next;
  logic              bit_done;
`ifdef UART_TX_PARITY_EN
  logic              parity_reg;
`endif

  assign push          = uart_wr_valid && ready_reg;
  assign fifo_nonempty = (count_reg != '0);
  assign count_next    = count_reg + FCNT_W'(push) - FCNT_W'(pop);
  assign bit_done      = (baud_cnt_reg == BIT_LAST);

  // FIFO storage write; contents need no reset because the count governs validity
  always_ff @(posedge clk_100m00) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= uart_wr_data;
    end
  end

  // FIFO pointers, occupancy and registered ready (ready reflects the count, never a same-cycle pop)
  always_ff @(posedge clk_100m00 or negedge uart_rst) begin
    if (!uart_rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      ready_reg  <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg <= count_next;
      ready_reg <= (count_next < FIFO_FULL);
    end
  end

  // FSM and datapath registers; reset forces the line high immediately
  always_ff @(posedge clk_100m00 or negedge uart_rst) begin
    if (!uart_rst) begin
      state_reg    <= IDLE;
      baud_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      txd_reg      <= 1'b1;
    end else begin
      state_reg    <= state_next;
      baud_cnt_reg <= baud_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      shift_reg    <= shift_next;
      txd_reg      <= txd_next;
    end
  end

`ifdef UART_TX_PARITY_EN
  // Even parity of the byte is captured as it leaves the FIFO
  always_ff @(posedge clk_100m00 or negedge uart_rst) begin
    if (!uart_rst) begin
      parity_reg <= 1'b0;
    end else if (pop) begin
      parity_reg <= ^fifo_mem[rd_ptr_reg];
    end
  end
`endif

  // Next-state logic: bit timing, bit counting, and FIFO pops at frame boundaries
  always_comb begin
    state_next    = state_reg;
    baud_cnt_next = baud_cnt_reg;
    bit_cnt_next  = bit_cnt_reg;
    shift_next    = shift_reg;
    pop           = 1'b0;
    case (state_reg)
      IDLE: begin
        if (fifo_nonempty) begin
          pop           = 1'b1;
          shift_next    = fifo_mem[rd_ptr_reg];
          baud_cnt_next = '0;
          bit_cnt_next  = '0;
          state_next    = START;
        end
      end
      START: begin
        if (bit_done) begin
          baud_cnt_next = '0;
          state_next    = DATA;
        end else begin
          baud_cnt_next = baud_cnt_reg + CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_done) begin
          baud_cnt_next = '0;
          shift_next    = {1'b0, shift_reg[7:1]};
          if (bit_cnt_reg == 3'd7) begin
            bit_cnt_next = '0;
`ifdef UART_TX_PARITY_EN
            state_next   = PARITY;
`else
            state_next   = STOP;
`endif
          end else begin
            bit_cnt_next = bit_cnt_reg + 3'd1;
          end
        end else begin
          baud_cnt_next = baud_cnt_reg + CNT_W'(1);
        end
      end
      PARITY: begin
        if (bit_done) begin
          baud_cnt_next = '0;
          state_next    = STOP;
        end else begin
          baud_cnt_next = baud_cnt_reg + CNT_W'(1);
        end
      end
      STOP: begin
        if (bit_done) begin
          baud_cnt_next = '0;
          // Back-to-back frames: the next start bit follows the stop bit directly
          if (fifo_nonempty) begin
            pop        = 1'b1;
            shift_next = fifo_mem[rd_ptr_reg];
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end else begin
          baud_cnt_next = baud_cnt_reg + CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Line level for the current state; registered one cycle later
  always_comb begin
    txd_next = 1'b1;
    case (state_reg)
      START:   txd_next = 1'b0;
      DATA:    txd_next = shift_reg[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  txd_next = parity_reg;
`endif
      default: txd_next = 1'b1;
    endcase
  end

  assign uart_txd      = txd_reg;
  assign uart_wr_ready = ready_reg;
  assign tx_busy       = fifo_nonempty || (state_reg != IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx.
// One instance runs at the default 868-cycle bit period for exact waveform,
// latency and reset checks. A second instance with an 11-cycle period carries
// the table, streaming, handshake and random loopback traffic. A serial
// receiver model decodes that line into a queue. Honours UART_TX_PARITY_EN.
`ifdef UART_TX_PARITY_EN
`define FRM(d, p) {1'b1, p, d, 1'b0}
`else
`define FRM(d, p) {1'b0, 1'b1, d, 1'b0}
`endif

module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int D_DIV   = 868;  // round(100e6 / 115200)
  localparam int F_DIV   = 11;   // round(1e6 / 95000) = round(10.53)
  localparam int F_DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [7:0] d_data, f_data;
  logic       d_valid, f_valid;
  logic       d_ready, f_ready, d_txd, f_txd, d_busy, f_busy;

  uart_tx u_dut (
    .clk_100m00(clk), .uart_rst(rst_n), .uart_wr_data(d_data), .uart_wr_valid(d_valid),
    .uart_wr_ready(d_ready), .uart_txd(d_txd), .tx_busy(d_busy)
  );

  uart_tx #(.CLK_FREQ(1000000), .BAUD_RATE(95000), .FIFO_DEPTH(F_DEPTH)) u_fast (
    .clk_100m00(clk), .uart_rst(rst_n), .uart_wr_data(f_data), .uart_wr_valid(f_valid),
    .uart_wr_ready(f_ready), .uart_txd(f_txd), .tx_busy(f_busy)
  );

  int checks = 0;
  int failures = 0;
  int unsigned cyc = 0;
  int frame_err = 0;
  int drop_acc;
  logic [7:0]  tx_list [$];
  logic [7:0]  exp_q [$];
  logic [7:0]  rx_q [$];
  logic [10:0] rx_bits_q [$];
  int unsigned rx_t_q [$];

  typedef struct {
    logic [7:0]  data;
    logic [10:0] frame;
  } vec_t;
  vec_t tbl [8];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Expected line bits in time order (index 0 = start bit), from the framing rules
  function automatic logic [10:0] frame_of(input logic [7:0] d);
    logic [10:0] f;
    f      = '0;
    f[8:1] = d;
`ifdef UART_TX_PARITY_EN
    f[9]   = ^d;
    f[10]  = 1'b1;
`else
    f[9]   = 1'b1;
`endif
    return f;
  endfunction

  // Serial receiver model on the fast line: sample each bit mid-period
  initial begin : rx_mon
    logic [10:0] bits;
    int unsigned t0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && f_txd === 1'b0) begin
        t0   = cyc;
        bits = '0;
        repeat (F_DIV / 2) @(negedge clk);
        bits[0] = f_txd;
        for (int k = 1; k < NB; k++) begin
          repeat (F_DIV) @(negedge clk);
          bits[k] = f_txd;
        end
        if (bits[0] !== 1'b0 || bits[NB-1] !== 1'b1) frame_err++;
`ifdef UART_TX_PARITY_EN
        if (bits[9] !== ^bits[8:1]) frame_err++;
`endif
        rx_q.push_back(bits[8:1]);
        rx_bits_q.push_back(bits);
        rx_t_q.push_back(t0);
      end
    end
  end

  task automatic clear_q();
    rx_q.delete(); rx_bits_q.delete(); rx_t_q.delete(); exp_q.delete();
  endtask

  // Offer tx_list to the fast instance. mode 0: valid held, 1: toggling, 2: random gaps
  task automatic f_drive(input int mode, input string tag);
    int idx = 0;
    int g = 0;
    bit v;
    drop_acc = -1;
    while (idx < tx_list.size() && g < 40000) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (g % 2 == 0);
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      f_valid = v;
      f_data  = v ? tx_list[idx] : 8'($urandom);
      if (f_ready === 1'b0 && drop_acc < 0) drop_acc = idx;
      if (v && f_ready === 1'b1) begin
        exp_q.push_back(tx_list[idx]);
        idx++;
      end
      @(negedge clk);
      g++;
    end
    f_valid = 1'b0;
    f_data  = '0;
    check({tag, "_all_accepted"}, idx, tx_list.size());
  endtask

  task automatic wait_rx(input int n, input string tag);
    int g = 0;
    int lim;
    lim = n * NB * F_DIV * 2 + 500;
    while (rx_q.size() < n && g < lim) begin
      @(negedge clk);
      g++;
    end
    check({tag, "_rx_arrived"}, rx_q.size() >= n, 1);
  endtask

  task automatic wait_idle_f(input string tag);
    int g = 0;
    while ((f_busy !== 1'b0 || f_txd !== 1'b1) && g < 3000) begin
      @(negedge clk);
      g++;
    end
    repeat (F_DIV) @(negedge clk);
    check({tag, "_idle_busy"}, f_busy, 0);
  endtask

  task automatic compare_stream(input string tag);
    check({tag, "_count"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), rx_q[i], exp_q[i]);
  endtask

  // One byte through the default instance: latency, every cycle of every bit, then idle
  task automatic d_frame(input logic [7:0] b, input string tag);
    logic [10:0] exp;
    int errs;
    exp = frame_of(b);
    d_data  = b;
    d_valid = 1'b1;
    check({tag, "_ready"}, d_ready, 1);
    @(negedge clk);                       // after accepting edge N
    d_valid = 1'b0;
    d_data  = '0;
    check({tag, "_txd_after_N"}, d_txd, 1);
    @(negedge clk);                       // after N+1
    check({tag, "_txd_after_N1"}, d_txd, 1);
    @(negedge clk);                       // after N+2: first start-bit cycle
    for (int k = 0; k < NB; k++) begin
      errs = 0;
      for (int c = 0; c < D_DIV; c++) begin
        if (k != 0 || c != 0) @(negedge clk);
        if (d_txd !== exp[k]) errs++;
        if (k == NB / 2 && c == 0) check({tag, "_busy_mid"}, d_busy, 1);
      end
      check($sformatf("%s_bit%0d_bad_cycles", tag, k), errs, 0);
    end
    @(negedge clk);
    check({tag, "_end_txd"}, d_txd, 1);
    check({tag, "_end_busy"}, d_busy, 0);
  endtask

  initial begin : main
    int g;
    rst_n = 1'b0;
    d_data = '0; d_valid = 1'b0;
    f_data = '0; f_valid = 1'b0;

    tbl[0] = '{8'hA5, `FRM(8'hA5, 1'b0)};
    tbl[1] = '{8'h01, `FRM(8'h01, 1'b1)};
    tbl[2] = '{8'hFF, `FRM(8'hFF, 1'b0)};
    tbl[3] = '{8'h00, `FRM(8'h00, 1'b0)};
    tbl[4] = '{8'h80, `FRM(8'h80, 1'b1)};
    tbl[5] = '{8'h3C, `FRM(8'h3C, 1'b0)};
    tbl[6] = '{8'h7E, `FRM(8'h7E, 1'b0)};
    tbl[7] = '{8'h13, `FRM(8'h13, 1'b1)};

    // Reset state across several edges, then ready on the first edge after release
    repeat (3) @(negedge clk);
    check("rst_txd", d_txd, 1);
    check("rst_ready", d_ready, 0);
    check("rst_busy", d_busy, 0);
    check("rst_fast_ready", f_ready, 0);
    rst_n = 1'b1;
    check("ready_before_first_edge", d_ready, 0);
    @(negedge clk);
    check("ready_after_first_edge", d_ready, 1);
    check("fast_ready_after_first_edge", f_ready, 1);

    // Single 0xA5 frame at the default bit period
    d_frame(8'hA5, "d_A5");
    repeat (5) @(negedge clk);

    // Fill the FIFO, then reset 3000 cycles into the first frame
    for (int i = 0; i < 3; i++) begin
      d_data  = 8'h11 * 8'(i + 1);
      d_valid = 1'b1;
      check($sformatf("rst_fill_ready%0d", i), d_ready, 1);
      @(negedge clk);
    end
    d_valid = 1'b0;
    d_data  = '0;
    g = 0;
    while (d_txd !== 1'b0 && g < 10) begin
      @(negedge clk);
      g++;
    end
    check("rst_frame_started", d_txd, 0);
    repeat (3000) @(negedge clk);
    check("rst_line_low_before", d_txd, 0);  // data bit 2 of 0x11
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_txd", d_txd, 1);
    check("rst_async_busy", d_busy, 0);
    check("rst_async_ready", d_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_fifo_discarded", d_busy, 0);
    d_frame(8'h3C, "d_3C_after_rst");
    repeat (2 * D_DIV) @(negedge clk);
    check("rst_no_stale_frames", d_busy, 0);

    // Table vectors on the fast instance
    for (int i = 0; i < 8; i++) begin
      clear_q();
      tx_list.delete();
      tx_list.push_back(tbl[i].data);
      f_drive(0, $sformatf("tbl%0d", i));
      wait_rx(1, $sformatf("tbl%0d", i));
      if (rx_bits_q.size() > 0)
        check($sformatf("tbl%0d_frame_%02h", i, tbl[i].data), rx_bits_q[0], tbl[i].frame);
      wait_idle_f($sformatf("tbl%0d", i));
    end

    // Valid held high with 8 bytes: ready drop point, order, zero-gap timing
    clear_q();
    tx_list = '{8'h81, 8'h42, 8'h24, 8'h18, 8'hE7, 8'h5A, 8'hA5, 8'hC3};
    f_drive(0, "stream");
    // One byte has already left for the line when the fourth stored entry fills the FIFO
    check("stream_accepts_before_ready_drop", drop_acc, F_DEPTH + 1);
    wait_rx(8, "stream");
    wait_idle_f("stream");
    compare_stream("stream");
    for (int i = 1; i < rx_t_q.size(); i++)
      check($sformatf("stream_gap%0d", i), rx_t_q[i] - rx_t_q[i-1], NB * F_DIV);
    if (rx_t_q.size() == 8)
      check("stream_total_cycles", rx_t_q[7] - rx_t_q[0] + NB * F_DIV, 8 * NB * F_DIV);

    // Valid toggling every cycle with random data on the off cycles
    clear_q();
    tx_list = '{8'h0F, 8'hF0, 8'h55, 8'hAA, 8'h12, 8'h34, 8'h56, 8'h78};
    f_drive(1, "toggle");
    wait_rx(8, "toggle");
    wait_idle_f("toggle");
    compare_stream("toggle");

    // Random bytes with random valid gaps, checked against the receiver model
    clear_q();
    tx_list.delete();
    for (int i = 0; i < 128; i++) tx_list.push_back(8'($urandom));
    f_drive(2, "rand");
    wait_rx(128, "rand");
    wait_idle_f("rand");
    compare_stream("rand");
    check("framing_errors", frame_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 100000000, input clock frequency in Hz.
REQ-002 The block SHALL have parameter BAUD_RATE, default 115200, line bit rate in bit/s.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 4, number of entries in the transmit FIFO; power of two, minimum 2.
REQ-004 The block SHALL have port clk_100m00  input  1  system clock; all logic is on its rising edge.
REQ-005 The block SHALL have port uart_rst  input  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have port uart_wr_data  input  8  byte to transmit.
REQ-007 The block SHALL have port uart_wr_valid  input  1  uart_wr_data is valid.
REQ-008 The block SHALL have port uart_wr_ready  output  1  block accepts a byte this cycle.
REQ-009 The block SHALL have port uart_txd  output  1  serial line, idle high, registered.
REQ-010 The block SHALL have port tx_busy  output  1  high while the FIFO is non-empty or a frame is on the line.

Function
REQ-011 The block SHALL use bit period DIV = round(CLK_FREQ/BAUD_RATE) cycles (868 at defaults), from a counter that reloads at the start of every bit.
REQ-012 A byte SHALL be accepted on a rising edge where uart_wr_valid and uart_wr_ready are both high, and pushed into the FIFO.
REQ-013 uart_wr_ready SHALL be high exactly when FIFO count < FIFO_DEPTH; a pop in the same cycle SHALL NOT raise ready (no pass-through when full).
REQ-014 uart_wr_data SHALL be ignored whenever uart_wr_valid is low or uart_wr_ready is low.
REQ-015 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP.
REQ-016 In IDLE with the FIFO non-empty, the FSM SHALL pop one byte into a shift register and enter START.
REQ-017 START SHALL drive uart_txd low for DIV cycles, then enter DATA.
REQ-018 DATA SHALL drive the 8 bits LSB first, DIV cycles each, using a 3-bit counter, then enter PARITY (macro defined) or STOP.
REQ-019 STOP SHALL drive uart_txd high for DIV cycles (one stop bit).
REQ-020 At the end of STOP, the FSM SHALL pop and enter START directly if the FIFO is non-empty (zero idle gap), otherwise enter IDLE.
REQ-021 For a byte accepted at edge N with the FIFO empty and the FSM in IDLE, uart_txd SHALL go low after edge N+2.
REQ-022 Simultaneous push and pop SHALL leave the FIFO count unchanged, with the FIFO pointers wrapping modulo FIFO_DEPTH.
REQ-023 In IDLE, uart_txd SHALL be high constantly.

Reset
REQ-024 While uart_rst is low: uart_txd=1, uart_wr_ready=0, tx_busy=0, FSM=IDLE, FIFO empty, all counters zero.
REQ-025 Reset asserted mid-frame SHALL abort the frame immediately (uart_txd high asynchronously) and discard the FIFO contents.
REQ-026 uart_wr_ready SHALL rise on the first rising edge after uart_rst deasserts.

Configuration
REQ-027 With macro UART_TX_PARITY_EN defined, the PARITY state SHALL drive the even parity bit (XOR of the 8 data bits) for DIV cycles between DATA and STOP; a frame is 11 bits.
REQ-028 Without UART_TX_PARITY_EN, the PARITY state SHALL never be entered and a frame is 10 bits (10*DIV cycles).

Verification
REQ-029 Single byte 0xA5 at defaults, no parity -> uart_txd sequence 0,1,0,1,0,0,1,0,1,1, each bit 868 cycles, frame 8680 cycles, then idle high with tx_busy=0.
REQ-030 Byte 0xA5 with UART_TX_PARITY_EN defined -> parity bit 0 before the stop bit; byte 0x01 -> parity bit 1; frame 9548 cycles.
REQ-031 uart_wr_valid held high with 8 distinct bytes -> uart_wr_ready drops when count=4; all 8 bytes are emitted in order with no idle gap, total 69440 cycles from the first start edge.
REQ-032 Reset pulse at cycle 3000 of a frame -> uart_txd=1 within the same cycle; FIFO empty; the next accepted byte 0x3C is transmitted correctly.
REQ-033 Loopback of uart_txd into the existing uart receiver, sending 128 random bytes -> the received byte stream matches the sent stream exactly, with no framing errors.
REQ-034 uart_wr_valid toggling every cycle for 8 bytes -> only handshaked bytes are transmitted; no duplicates and no drops.
